// File: rtl/cp0_ctrl_if.sv
// cp0_ctrl_if: MTC0/MFC0, interrupt and exception signals between the pipeline
// (master) and the CP0 register block (slave).
interface cp0_ctrl_if #(
    parameter int HW_INT = 6
);
    logic              we_i;
    logic [4:0]        waddr_i;
    logic [4:0]        raddr_i;
    logic [31:0]       data_i;
    logic [HW_INT-1:0] int_i;
    logic [31:0]       excepttype_i;
    logic [31:0]       current_inst_addr_i;
    logic              is_in_delay_slot_i;
    logic [31:0]       bad_address_i;

    logic [31:0]       data_o;
    logic [31:0]       status_o;
    logic [31:0]       cause_o;
    logic [31:0]       epc_o;
    logic [31:0]       ebase_o;
    logic [31:0]       index_o;
    logic [31:0]       random_o;
    logic [31:0]       wired_o;
    logic [31:0]       entryhi_o;
    logic              timer_int_o;
    logic              int_req_o;

    modport master (
        output we_i, waddr_i, raddr_i, data_i, int_i, excepttype_i,
               current_inst_addr_i, is_in_delay_slot_i, bad_address_i,
        input  data_o, status_o, cause_o, epc_o, ebase_o, index_o, random_o,
               wired_o, entryhi_o, timer_int_o, int_req_o
    );

    modport slave (
        input  we_i, waddr_i, raddr_i, data_i, int_i, excepttype_i,
               current_inst_addr_i, is_in_delay_slot_i, bad_address_i,
        output data_o, status_o, cause_o, epc_o, ebase_o, index_o, random_o,
               wired_o, entryhi_o, timer_int_o, int_req_o
    );
endinterface

// File: rtl/cp0_ctrl.sv
// cp0_ctrl: MIPS32 coprocessor 0 register block -- Count/Compare timer,
// interrupt sampling, exception entry/ERET bookkeeping and the TLB helper
// registers (Index, Random, Wired, EntryLo0/1, PageMask, EntryHi).
// Optional feature: define CP0_COUNT_DIV2_EN to advance Count every second cycle.
module cp0_ctrl #(
    parameter int TLB_ENTRIES = 16,
    parameter int HW_INT      = 6
) (
    input  logic      clk,
    input  logic      rst,
    cp0_ctrl_if.slave bus
);
    localparam int               IDX_W    = $clog2(TLB_ENTRIES);
    localparam logic [IDX_W-1:0] RAND_TOP = IDX_W'(TLB_ENTRIES - 1);
    localparam logic [IDX_W-1:0] RAND_ONE = IDX_W'(1);

    localparam logic [4:0] REG_INDEX    = 5'd0;
    localparam logic [4:0] REG_RANDOM   = 5'd1;
    localparam logic [4:0] REG_ENTRYLO0 = 5'd2;
    localparam logic [4:0] REG_ENTRYLO1 = 5'd3;
    localparam logic [4:0] REG_PAGEMASK = 5'd5;
    localparam logic [4:0] REG_WIRED    = 5'd6;
    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_ENTRYHI  = 5'd10;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_EBASE    = 5'd15;
    localparam logic [4:0] REG_CONFIG   = 5'd16;

    localparam logic [31:0] MASK_ENTRYLO = 32'h03FF_FFFF;
    localparam logic [31:0] MASK_PAGEMSK = 32'h1FFF_E000;
    localparam logic [31:0] MASK_ENTRYHI = 32'hFFFF_E0FF;
    localparam logic [31:0] MASK_EBASE   = 32'h3FFF_F000;

    localparam logic [31:0] STATUS_RST = 32'h1000_0000;
    localparam logic [31:0] CONFIG_VAL = 32'h0000_8000;
    localparam logic [31:0] EBASE_RST  = 32'h8000_0000;

    logic [31:0]       count_q, compare_q, status_q, epc_q, badvaddr_q;
    logic [31:0]       entrylo0_q, entrylo1_q, pagemask_q, entryhi_q, ebase_q;
    logic [IDX_W-1:0]  index_q, random_q, wired_q;
    logic              index_p_q;
    logic              timer_q;
    logic              cause_bd_q;
    logic [4:0]        cause_exc_q;
    logic [1:0]        cause_sw_q;   // Cause.IP[1:0], software interrupts
    logic [1:0]        cause_hi_q;   // Cause[23:22]
    logic [HW_INT-1:0] int_q;
    logic              count_tick;

    // MTC0 write strobes, one per writable register
    logic wr_index, wr_entrylo0, wr_entrylo1, wr_pagemask, wr_wired, wr_count;
    logic wr_entryhi, wr_compare, wr_status, wr_cause, wr_epc, wr_ebase;
    assign wr_index    = bus.we_i && (bus.waddr_i == REG_INDEX);
    assign wr_entrylo0 = bus.we_i && (bus.waddr_i == REG_ENTRYLO0);
    assign wr_entrylo1 = bus.we_i && (bus.waddr_i == REG_ENTRYLO1);
    assign wr_pagemask = bus.we_i && (bus.waddr_i == REG_PAGEMASK);
    assign wr_wired    = bus.we_i && (bus.waddr_i == REG_WIRED);
    assign wr_count    = bus.we_i && (bus.waddr_i == REG_COUNT);
    assign wr_entryhi  = bus.we_i && (bus.waddr_i == REG_ENTRYHI);
    assign wr_compare  = bus.we_i && (bus.waddr_i == REG_COMPARE);
    assign wr_status   = bus.we_i && (bus.waddr_i == REG_STATUS);
    assign wr_cause    = bus.we_i && (bus.waddr_i == REG_CAUSE);
    assign wr_epc      = bus.we_i && (bus.waddr_i == REG_EPC);
    assign wr_ebase    = bus.we_i && (bus.waddr_i == REG_EBASE);

    logic       exc_valid, exc_eret, exc_badaddr, exc_is_int, epc_update;
    logic [4:0] exc_code;

    // Decode the MEM-stage exception code into an ExcCode and side effects.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        exc_valid   = 1'b0;
        exc_eret    = 1'b0;
        exc_badaddr = 1'b0;
        exc_code    = 5'd0;
        case (bus.excepttype_i)
            32'h0000_0001: begin exc_valid = 1'b1; exc_code = 5'd0;  end
            32'h0000_0008: begin exc_valid = 1'b1; exc_code = 5'd8;  end
            32'h0000_000a: begin exc_valid = 1'b1; exc_code = 5'd10; end
            32'h0000_000c: begin exc_valid = 1'b1; exc_code = 5'd12; end
            32'h0000_000d: begin exc_valid = 1'b1; exc_code = 5'd13; end
            32'h0000_000f: begin exc_valid = 1'b1; exc_code = 5'd4; exc_badaddr = 1'b1; end
            32'h0000_0010: begin exc_valid = 1'b1; exc_code = 5'd5; exc_badaddr = 1'b1; end
            32'h0000_000e: exc_eret = 1'b1;
            default:       ;
        endcase
    end

    // Interrupts always refresh EPC/BD; other exceptions only when not already nested.
    assign exc_is_int = (bus.excepttype_i == 32'h0000_0001);
    assign epc_update = exc_valid && (!status_q[1] || exc_is_int);

`ifdef CP0_COUNT_DIV2_EN
    logic div_q;

    // Free-running toggle that halves the Count rate; first tick on the second cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) div_q <= 1'b0;
        else     div_q <= ~div_q;
    end

    assign count_tick = div_q;
`else
    assign count_tick = 1'b1;
`endif

    // Count advances on each tick; an MTC0 to Count overrides the increment.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             count_q <= 32'd0;
        else if (wr_count)   count_q <= bus.data_i;
        else if (count_tick) count_q <= count_q + 32'd1;
    end

    // Sticky timer interrupt: set on Count == Compare (Compare non-zero), cleared by writing Compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                           timer_q <= 1'b0;
        else if (wr_compare)                               timer_q <= 1'b0;
        else if ((count_q == compare_q) && (compare_q != 0)) timer_q <= 1'b1;
    end

    // Random walks down from TLB_ENTRIES-1 to Wired, then wraps; a Wired write restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                              random_q <= RAND_TOP;
        else if (wr_wired)                                    random_q <= RAND_TOP;
        else if ((random_q <= wired_q) || (wired_q >= RAND_TOP)) random_q <= RAND_TOP;
        else                                                  random_q <= random_q - RAND_ONE;
    end

    // Plain MTC0-only registers, each with its architectural write mask.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            compare_q  <= 32'd0;
            index_q    <= '0;
            index_p_q  <= 1'b0;
            wired_q    <= '0;
            entrylo0_q <= 32'd0;
            entrylo1_q <= 32'd0;
            pagemask_q <= 32'd0;
            entryhi_q  <= 32'd0;
            ebase_q    <= EBASE_RST;
        end else begin
            if (wr_compare)  compare_q  <= bus.data_i;
            if (wr_index) begin
                index_q   <= bus.data_i[IDX_W-1:0];
                index_p_q <= bus.data_i[31];
            end
            if (wr_wired)    wired_q    <= bus.data_i[IDX_W-1:0];
            if (wr_entrylo0) entrylo0_q <= bus.data_i & MASK_ENTRYLO;
            if (wr_entrylo1) entrylo1_q <= bus.data_i & MASK_ENTRYLO;
            if (wr_pagemask) pagemask_q <= bus.data_i & MASK_PAGEMSK;
            if (wr_entryhi)  entryhi_q  <= bus.data_i & MASK_ENTRYHI;
            if (wr_ebase)    ebase_q    <= (ebase_q & ~MASK_EBASE) | (bus.data_i & MASK_EBASE);
        end
    end

    // Status/Cause/EPC/BadVAddr: MTC0 first, exception/ERET updates afterwards so they win per field.
    // NOTE: of several non-blocking writes to one bit in a block, the last one executed takes effect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q    <= STATUS_RST;
            epc_q       <= 32'd0;
            badvaddr_q  <= 32'd0;
            cause_bd_q  <= 1'b0;
            cause_exc_q <= 5'd0;
            cause_sw_q  <= 2'd0;
            cause_hi_q  <= 2'd0;
            int_q       <= '0;
        end else begin
            int_q <= bus.int_i;
            if (wr_status) status_q <= bus.data_i;
            if (wr_epc)    epc_q    <= bus.data_i;
            if (wr_cause) begin
                cause_sw_q <= bus.data_i[9:8];
                cause_hi_q <= bus.data_i[23:22];
            end
            if (exc_valid) begin
                if (epc_update) begin
                    epc_q      <= bus.is_in_delay_slot_i ? (bus.current_inst_addr_i - 32'd4)
                                                         : bus.current_inst_addr_i;
                    cause_bd_q <= bus.is_in_delay_slot_i;
                end
                status_q[1] <= 1'b1;
                cause_exc_q <= exc_code;
                if (exc_badaddr) badvaddr_q <= bus.bad_address_i;
            end else if (exc_eret) begin
                status_q[1] <= 1'b0;
            end
        end
    end

    // Assembled read views of the composite registers.
    logic [5:0]  ip_hw;
    logic [7:0]  cause_ip;
    logic [31:0] cause_val, index_val, random_val, wired_val;
    assign ip_hw      = 6'(int_q);
    assign cause_ip   = {ip_hw[5] | timer_q, ip_hw[4:0], cause_sw_q};
    assign cause_val  = {cause_bd_q, 7'd0, cause_hi_q, 6'd0, cause_ip, 1'b0, cause_exc_q, 2'd0};
    assign index_val  = {index_p_q, {(31-IDX_W){1'b0}}, index_q};
    assign random_val = {{(32-IDX_W){1'b0}}, random_q};
    assign wired_val  = {{(32-IDX_W){1'b0}}, wired_q};

    assign bus.status_o    = status_q;
    assign bus.cause_o     = cause_val;
    assign bus.epc_o       = epc_q;
    assign bus.ebase_o     = ebase_q;
    assign bus.index_o     = index_val;
    assign bus.random_o    = random_val;
    assign bus.wired_o     = wired_val;
    assign bus.entryhi_o   = entryhi_q;
    assign bus.timer_int_o = timer_q;
    assign bus.int_req_o   = status_q[0] & ~status_q[1] & (|(cause_ip & status_q[15:8]));

    // MFC0 read mux; held at zero while reset is asserted.
    always_comb begin
        bus.data_o = 32'd0;
        if (!rst) begin
            case (bus.raddr_i)
                REG_INDEX:    bus.data_o = index_val;
                REG_RANDOM:   bus.data_o = random_val;
                REG_ENTRYLO0: bus.data_o = entrylo0_q;
                REG_ENTRYLO1: bus.data_o = entrylo1_q;
                REG_PAGEMASK: bus.data_o = pagemask_q;
                REG_WIRED:    bus.data_o = wired_val;
                REG_BADVADDR: bus.data_o = badvaddr_q;
                REG_COUNT:    bus.data_o = count_q;
                REG_ENTRYHI:  bus.data_o = entryhi_q;
                REG_COMPARE:  bus.data_o = compare_q;
                REG_STATUS:   bus.data_o = status_q;
                REG_CAUSE:    bus.data_o = cause_val;
                REG_EPC:      bus.data_o = epc_q;
                REG_EBASE:    bus.data_o = ebase_q;
                REG_CONFIG:   bus.data_o = CONFIG_VAL;
                default:      bus.data_o = 32'd0;
            endcase
        end
    end
endmodule

// File: tb/tb_cp0_ctrl.sv
// tb_cp0_ctrl: directed scenarios with literal expectations, then randomized
// MTC0/interrupt/exception traffic checked every cycle against a register-file
// model driven by per-register write-mask tables.
module tb_cp0_ctrl;
    localparam int TLB_ENTRIES = 16;
    localparam int HW_INT      = 6;
    localparam int IDX_W       = $clog2(TLB_ENTRIES);
    localparam logic [31:0] TOP      = 32'(TLB_ENTRIES - 1);
    localparam logic [31:0] IDX_MASK = (32'd1 << IDX_W) - 32'd1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cmp_en = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    cp0_ctrl_if #(.HW_INT(HW_INT)) bus ();

    cp0_ctrl #(.TLB_ENTRIES(TLB_ENTRIES), .HW_INT(HW_INT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- reference model ----------------
    logic [31:0]       m_reg [0:31];
    logic              m_timer;
    logic [HW_INT-1:0] m_int;
    logic              m_tog;

    function automatic logic [31:0] wmask(input int a);
        case (a)
            0:              return 32'h8000_0000 | IDX_MASK;
            2, 3:           return 32'h03FF_FFFF;
            5:              return 32'h1FFF_E000;
            6:              return IDX_MASK;
            9, 11, 12, 14:  return 32'hFFFF_FFFF;
            10:             return 32'hFFFF_E0FF;
            13:             return 32'h00C0_0300;
            15:             return 32'h3FFF_F000;
            default:        return 32'd0;
        endcase
    endfunction

    function automatic int exc_num(input logic [31:0] t);
        case (t)
            32'h01:  return 0;
            32'h08:  return 8;
            32'h0a:  return 10;
            32'h0c:  return 12;
            32'h0d:  return 13;
            32'h0f:  return 4;
            32'h10:  return 5;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
        m_reg[1]  = TOP;
        m_reg[12] = 32'h1000_0000;
        m_reg[15] = 32'h8000_0000;
        m_reg[16] = 32'h0000_8000;
        m_timer = 1'b0;
        m_int   = '0;
        m_tog   = 1'b0;
    endtask

    task automatic model_step();
        logic [31:0] o [0:31];
        logic [31:0] n [0:31];
        int          w;
        int          ec;
        logic        tick;
        o = m_reg;
        n = m_reg;
        w = int'(bus.waddr_i);
        if (bus.we_i) n[w] = (o[w] & ~wmask(w)) | (bus.data_i & wmask(w));
`ifdef CP0_COUNT_DIV2_EN
        tick  = m_tog;
        m_tog = ~m_tog;
`else
        tick = 1'b1;
`endif
        if (!(bus.we_i && w == 9) && tick) n[9] = o[9] + 32'd1;
        if (bus.we_i && w == 6)                n[1] = TOP;
        else if (o[1] <= o[6] || o[6] >= TOP)  n[1] = TOP;
        else                                   n[1] = o[1] - 32'd1;
        if (bus.we_i && w == 11)               m_timer = 1'b0;
        else if (o[9] == o[11] && o[11] != 0)  m_timer = 1'b1;
        ec = exc_num(bus.excepttype_i);
        if (ec >= 0) begin
            if (o[12][1] == 1'b0 || bus.excepttype_i == 32'h01) begin
                n[14]     = bus.is_in_delay_slot_i ? bus.current_inst_addr_i - 32'd4
                                                   : bus.current_inst_addr_i;
                n[13][31] = bus.is_in_delay_slot_i;
            end
            n[12][1]   = 1'b1;
            n[13][6:2] = 5'(ec);
            if (ec == 4 || ec == 5) n[8] = bus.bad_address_i;
        end else if (bus.excepttype_i == 32'h0e) begin
            n[12][1] = 1'b0;
        end
        m_int = bus.int_i;
        m_reg = n;
    endtask

    function automatic logic [31:0] m_cause();
        return m_reg[13] | (32'(m_int) << 10) | (32'(m_timer) << 15);
    endfunction

    function automatic logic m_intreq();
        logic [31:0] c;
        logic [31:0] s;
        c = m_cause();
        s = m_reg[12];
        return s[0] & ~s[1] & (|(c[15:8] & s[15:8]));
    endfunction

    function automatic logic [31:0] m_read(input int a);
        if (rst) return 32'd0;
        case (a)
            13:                                              return m_cause();
            0, 1, 2, 3, 5, 6, 8, 9, 10, 11, 12, 14, 15, 16: return m_reg[a];
            default:                                         return 32'd0;
        endcase
    endfunction

    // Model advances on the same edges as the design.
    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every visible output against the model mid-cycle.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("status_o",    bus.status_o,        m_reg[12]);
            check("cause_o",     bus.cause_o,         m_cause());
            check("epc_o",       bus.epc_o,           m_reg[14]);
            check("ebase_o",     bus.ebase_o,         m_reg[15]);
            check("index_o",     bus.index_o,         m_reg[0]);
            check("random_o",    bus.random_o,        m_reg[1]);
            check("wired_o",     bus.wired_o,         m_reg[6]);
            check("entryhi_o",   bus.entryhi_o,       m_reg[10]);
            check("timer_int_o", 32'(bus.timer_int_o), 32'(m_timer));
            check("int_req_o",   32'(bus.int_req_o),   32'(m_intreq()));
            check("data_o",      bus.data_o,          m_read(int'(bus.raddr_i)));
        end
    end

    // ---------------- stimulus ----------------
    int wr_list  [15] = '{0, 1, 2, 3, 5, 6, 8, 9, 10, 11, 12, 13, 14, 15, 16};
    logic [31:0] exc_list [8] = '{32'h01, 32'h08, 32'h0a, 32'h0c, 32'h0d, 32'h0f, 32'h10, 32'h0e};

    task automatic set_idle();
        bus.we_i                = 1'b0;
        bus.waddr_i             = 5'd0;
        bus.raddr_i             = 5'd0;
        bus.data_i              = 32'd0;
        bus.int_i               = '0;
        bus.excepttype_i        = 32'd0;
        bus.current_inst_addr_i = 32'd0;
        bus.is_in_delay_slot_i  = 1'b0;
        bus.bad_address_i       = 32'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.we_i    = 1'b1;
        bus.waddr_i = a;
        bus.data_i  = d;
        step();
        bus.we_i = 1'b0;
    endtask

    task automatic raise(input logic [31:0] t, input logic [31:0] pc, input logic ds,
                         input logic [31:0] bad);
        bus.excepttype_i        = t;
        bus.current_inst_addr_i = pc;
        bus.is_in_delay_slot_i  = ds;
        bus.bad_address_i       = bad;
        step();
        bus.excepttype_i = 32'd0;
        bus.we_i         = 1'b0;
    endtask

    task automatic rand_inputs();
        int r;
        bus.we_i    = ($urandom_range(0, 99) < 30);
        bus.waddr_i = ($urandom_range(0, 9) < 8) ? 5'(wr_list[$urandom_range(0, 14)])
                                                 : 5'($urandom_range(0, 31));
        bus.data_i  = $urandom;
        r = int'($urandom_range(0, 1));
        if (bus.waddr_i == 5'd11 && r == 1) bus.data_i = m_reg[9] + 32'($urandom_range(1, 6));
        if (bus.waddr_i == 5'd9  && r == 1) bus.data_i = m_reg[11] - 32'd2;
        if (bus.waddr_i == 5'd12 && r == 1) bus.data_i = ($urandom & 32'hFFFF_FF00) | 32'h1;
        bus.raddr_i = 5'($urandom_range(0, 31));
        bus.int_i   = HW_INT'($urandom);
        bus.excepttype_i = ($urandom_range(0, 99) < 88) ? 32'd0 : exc_list[$urandom_range(0, 7)];
        bus.current_inst_addr_i = $urandom & 32'hFFFF_FFFC;
        bus.is_in_delay_slot_i  = 1'($urandom);
        bus.bad_address_i       = $urandom;
    endtask

    initial begin
        int k;
        set_idle();
        model_reset();
        rst = 1'b1;
        bus.raddr_i = 5'd16;
        repeat (3) step();

        // Reset values
        check("rst_status", bus.status_o, 32'h1000_0000);
        check("rst_ebase",  bus.ebase_o,  32'h8000_0000);
        check("rst_random", bus.random_o, 32'd15);
        check("rst_data_o", bus.data_o,   32'd0);
        check("rst_timer",  32'(bus.timer_int_o), 32'd0);

        // Idle five cycles after release
        rst = 1'b0;
        bus.raddr_i = 5'd9;
        repeat (5) step();
`ifndef CP0_COUNT_DIV2_EN
        check("idle_count", bus.data_o, 32'd5);
`endif
        check("idle_random", bus.random_o, 32'd10);
        check("idle_status", bus.status_o, 32'h1000_0000);
        bus.raddr_i = 5'd16;
        #1;
        check("config", bus.data_o, 32'h0000_8000);

        // Timer interrupt via Compare
        mtc0(5'd11, 32'd20);
        mtc0(5'd12, 32'h0000_8001);
        k = 0;
        while (!bus.timer_int_o && k < 80) begin
            step();
            k++;
        end
        check("timer_set",   32'(bus.timer_int_o), 32'd1);
        check("int_req_set", 32'(bus.int_req_o),   32'd1);
        mtc0(5'd11, 32'd0);
        check("timer_clr",   32'(bus.timer_int_o), 32'd0);
        check("int_req_clr", 32'(bus.int_req_o),   32'd0);

        // Random sequence with Wired = 3
        mtc0(5'd6, 32'd3);
        for (int i = 0; i < 14; i++) begin
            check("random_seq", bus.random_o, (i <= 12) ? 32'(15 - i) : 32'd15);
            step();
        end

        // Exception in delay slot, then nested exception
        raise(32'h0a, 32'h8000_1004, 1'b1, 32'd0);
        check("exc_epc",  bus.epc_o, 32'h8000_1000);
        check("exc_bd",   32'(bus.cause_o[31]),  32'd1);
        check("exc_code", 32'(bus.cause_o[6:2]), 32'd10);
        check("exc_exl",  32'(bus.status_o[1]),  32'd1);
        raise(32'h08, 32'h8000_2000, 1'b0, 32'd0);
        check("nest_epc",  bus.epc_o, 32'h8000_1000);
        check("nest_code", 32'(bus.cause_o[6:2]), 32'd8);
        check("nest_bd",   32'(bus.cause_o[31]),  32'd1);

        // Address error with same-cycle MTC0 Status = 0, then ERET
        bus.we_i    = 1'b1;
        bus.waddr_i = 5'd12;
        bus.data_i  = 32'd0;
        raise(32'h0f, 32'h8000_3000, 1'b0, 32'h0040_0003);
        bus.raddr_i = 5'd8;
        #1;
        check("badvaddr",    bus.data_o,   32'h0040_0003);
        check("ae_status",   bus.status_o, 32'h0000_0002);
        raise(32'h0e, 32'h0, 1'b0, 32'd0);
        check("eret_status", bus.status_o, 32'h0000_0000);

        // Interrupt exception refreshes EPC/BD even when EXL is already set
        raise(32'h0c, 32'h0000_0100, 1'b0, 32'd0);
        raise(32'h01, 32'h0000_0200, 1'b1, 32'd0);
        check("int_epc", bus.epc_o, 32'h0000_01FC);
        check("int_bd",  32'(bus.cause_o[31]),  32'd1);
        check("int_code", 32'(bus.cause_o[6:2]), 32'd0);

        // Randomized traffic with one mid-run reset
        for (int i = 0; i < 1500; i++) begin
            if (i == 800) begin
                rst = 1'b1;
                #1;
                check("midrst_status", bus.status_o, 32'h1000_0000);
                check("midrst_random", bus.random_o, 32'd15);
                check("midrst_timer",  32'(bus.timer_int_o), 32'd0);
                check("midrst_epc",    bus.epc_o, 32'd0);
                check("midrst_data_o", bus.data_o, 32'd0);
                step();
                rst = 1'b0;
            end
            rand_inputs();
            step();
        end

        set_idle();
        step();
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
